// File: rtl/uart_relay_pkg.sv
// Shared definitions for the UART line relay.
// Contents: ASCII control bytes, default UART register addresses,
// the relay FSM state type and the transmit byte-substitution helper.
package uart_relay_pkg;

  localparam logic [7:0]  ASCII_CR    = 8'h0d;
  localparam logic [7:0]  ASCII_LF    = 8'h0a;
  localparam logic [31:0] DEF_RX_ADDR = 32'h1001_0000;
  localparam logic [31:0] DEF_TX_ADDR = 32'h1001_0004;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_TX_LF   = 2'd2
  } relay_state_t;

  function automatic logic [7:0] subst_byte(input logic [7:0] b,
                                            input logic [7:0] from_b,
                                            input logic [7:0] to_b);
    return (b == from_b) ? to_b : b;
  endfunction

endpackage

// File: rtl/uart_line_relay_if.sv
// Bus between the line relay (master) and the UART register block (slave).
//   addr_32b_o       master->slave  register address
//   wren_o / rden_o  master->slave  single-cycle write / read strobes
//   din_32b_o        master->slave  write data {24'b0, byte}
//   dout_32b_i       slave->master  read data, byte in [7:0]
//   dout_32b_valid_i slave->master  read data valid, one cycle
//   interrupt_i      slave->master  RX data available (level)
interface uart_line_relay_if;
  logic [31:0] addr_32b_o;
  logic        wren_o;
  logic        rden_o;
  logic [31:0] din_32b_o;
  logic [31:0] dout_32b_i;
  logic        dout_32b_valid_i;
  logic        interrupt_i;

  modport master (
    output addr_32b_o, wren_o, rden_o, din_32b_o,
    input  dout_32b_i, dout_32b_valid_i, interrupt_i
  );

  modport slave (
    input  addr_32b_o, wren_o, rden_o, din_32b_o,
    output dout_32b_i, dout_32b_valid_i, interrupt_i
  );
endinterface

// File: rtl/uart_line_relay_fifo.sv
// First-word-fall-through synchronous FIFO used as the relay line buffer.
//   sys_clk, rst_n : clock, asynchronous active-low reset (clears pointers)
//   push, din      : write request and data (ignored when full)
//   pop            : consume head entry (ignored when empty)
//   dout           : head entry, valid whenever empty is low
//   empty          : no entries held
//   free_cnt       : slots remaining, 0..2**DEPTH_LOG2
module sync_fifo_fwft #(
  parameter int DEPTH_LOG2 = 9,
  parameter int WIDTH      = 8
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   free_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (count_reg == '0);
  assign free_cnt = (DEPTH_LOG2+1)'(DEPTH) - count_reg;
  assign do_push  = push && (free_cnt != '0);
  assign do_pop   = pop && !empty;
  // Head is read straight from the array so it is visible before the pop.
  assign dout     = mem[rd_ptr_reg];

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/uart_line_relay.sv
// UART line relay: bus master that drains RX bytes from the UART into a line
// buffer and writes them back to the TX register with byte substitution and
// optional CR -> CR,LF expansion. Bus accesses are paced by a gap counter.
//   sys_clk, rst_n : clock, asynchronous active-low reset
//   bus            : master side of the UART register bus
//   line_cnt_o     : complete lines (CRs) held in the buffer
//   drop_cnt_o     : bytes dropped on overflow, saturating
//   busy_o         : FSM active or buffer non-empty
module uart_line_relay
  import uart_relay_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 9,
  parameter int          GAP_CLKS   = 16,
  parameter bit          LINE_MODE  = 1'b1,
  parameter bit          CRLF_EN    = 1'b1,
  parameter logic [7:0]  SUB_FROM   = 8'h41,
  parameter logic [7:0]  SUB_TO     = 8'h42,
  parameter logic [31:0] RX_ADDR    = DEF_RX_ADDR,
  parameter logic [31:0] TX_ADDR    = DEF_TX_ADDR,
  parameter int          RD_TIMEOUT = 15
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  uart_line_relay_if.master   bus,
  output logic [DEPTH_LOG2:0] line_cnt_o,
  output logic [15:0]         drop_cnt_o,
  output logic                busy_o
);
  localparam int GAP_W = $clog2(GAP_CLKS);
  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

  relay_state_t        state_reg, state_next;
  logic [GAP_W-1:0]    gap_reg;
  logic [TMO_W-1:0]    tmo_reg;
  logic [31:0]         addr_reg, din_reg;
  logic                wren_reg, rden_reg;
  logic [DEPTH_LOG2:0] line_cnt_reg;
  logic [15:0]         drop_cnt_reg;

  logic                issue_rd, issue_wr, rx_take;
  logic [7:0]          wr_byte;
  logic                fifo_push, fifo_pop, fifo_empty;
  logic [7:0]          fifo_dout, rx_byte;
  logic [DEPTH_LOG2:0] fifo_free;
  logic                send_ok, drop, lc_inc, lc_dec;

  sync_fifo_fwft #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(8)) u_fifo (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .din      (rx_byte),
    .pop      (fifo_pop),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .free_cnt (fifo_free)
  );

  assign rx_byte = bus.dout_32b_i[7:0];
  assign send_ok = !fifo_empty && (!LINE_MODE || (line_cnt_reg != '0));

  always_comb begin
    state_next = state_reg;
    issue_rd   = 1'b0;
    issue_wr   = 1'b0;
    rx_take    = 1'b0;
    fifo_pop   = 1'b0;
    wr_byte    = 8'h00;
    case (state_reg)
      ST_IDLE: begin
        if (gap_reg == '0) begin
          if (bus.interrupt_i) begin
            issue_rd   = 1'b1;
            state_next = ST_RD_WAIT;
          end else if (send_ok) begin
            fifo_pop = 1'b1;
            issue_wr = 1'b1;
            wr_byte  = subst_byte(fifo_dout, SUB_FROM, SUB_TO);
            if (CRLF_EN && (fifo_dout == ASCII_CR)) state_next = ST_TX_LF;
          end
        end
      end
      ST_RD_WAIT: begin
        if (bus.dout_32b_valid_i) begin
          rx_take    = 1'b1;
          state_next = ST_IDLE;
        end else if (tmo_reg == TMO_W'(RD_TIMEOUT - 1)) begin
          state_next = ST_IDLE;
        end
      end
      ST_TX_LF: begin
        // The LF is never substituted and is not pre-empted by RX reads.
        if (gap_reg == '0) begin
          issue_wr   = 1'b1;
          wr_byte    = ASCII_LF;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The last free slot is reserved for CR so a full buffer always ends a line
  // and line mode can still drain it.
  assign fifo_push = rx_take && ((fifo_free >= (DEPTH_LOG2+1)'(2)) ||
                     ((fifo_free == (DEPTH_LOG2+1)'(1)) && (rx_byte == ASCII_CR)));
  assign drop      = rx_take && !fifo_push;
  assign lc_inc    = fifo_push && (rx_byte == ASCII_CR);
  assign lc_dec    = fifo_pop && (fifo_dout == ASCII_CR);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      gap_reg      <= '0;
      tmo_reg      <= '0;
      addr_reg     <= '0;
      din_reg      <= '0;
      wren_reg     <= 1'b0;
      rden_reg     <= 1'b0;
      line_cnt_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      wren_reg  <= issue_wr;
      rden_reg  <= issue_rd;
      if (issue_rd) addr_reg <= RX_ADDR;
      else if (issue_wr) addr_reg <= TX_ADDR;
      if (issue_wr) din_reg <= {24'h0, wr_byte};
      if (issue_rd || issue_wr) gap_reg <= GAP_W'(GAP_CLKS - 1);
      else if (gap_reg != '0) gap_reg <= gap_reg - 1'b1;
      tmo_reg <= (state_reg == ST_RD_WAIT) ? tmo_reg + 1'b1 : '0;
      case ({lc_inc, lc_dec})
        2'b10:   line_cnt_reg <= line_cnt_reg + 1'b1;
        2'b01:   line_cnt_reg <= line_cnt_reg - 1'b1;
        default: line_cnt_reg <= line_cnt_reg;
      endcase
      if (drop && (drop_cnt_reg != 16'hffff)) drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign bus.addr_32b_o = addr_reg;
  assign bus.din_32b_o  = din_reg;
  assign bus.wren_o     = wren_reg;
  assign bus.rden_o     = rden_reg;
  assign line_cnt_o     = line_cnt_reg;
  assign drop_cnt_o     = drop_cnt_reg;
  assign busy_o         = (state_reg != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_uart_line_relay.sv
// Directed bench for uart_line_relay. Three instances: default (0),
// LINE_MODE=0/CRLF_EN=0 (1) and DEPTH_LOG2=2 (2). A small UART model answers
// reads from per-instance RX queues; expected TX bytes are queued when the
// stimulus is loaded and popped as writes appear on the bus.
module tb_uart_line_relay;
  import uart_relay_pkg::*;

  localparam int GAP = 16;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #10 sys_clk = ~sys_clk;

  uart_line_relay_if bus0 ();
  uart_line_relay_if bus1 ();
  uart_line_relay_if bus2 ();

  logic [9:0]  lc0, lc1;
  logic [2:0]  lc2;
  logic [15:0] dc0, dc1, dc2;
  logic        bz0, bz1, bz2;

  uart_line_relay dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .bus(bus0),
    .line_cnt_o(lc0), .drop_cnt_o(dc0), .busy_o(bz0)
  );
  uart_line_relay #(.LINE_MODE(1'b0), .CRLF_EN(1'b0)) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .bus(bus1),
    .line_cnt_o(lc1), .drop_cnt_o(dc1), .busy_o(bz1)
  );
  uart_line_relay #(.DEPTH_LOG2(2)) dut2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .bus(bus2),
    .line_cnt_o(lc2), .drop_cnt_o(dc2), .busy_o(bz2)
  );

  logic        wren_v [3];
  logic        rden_v [3];
  logic        busy_v [3];
  logic        irq_v  [3];
  logic        valid_v[3];
  logic [31:0] addr_v [3];
  logic [31:0] din_v  [3];
  logic [31:0] dout_v [3];
  logic [31:0] lc_v   [3];
  logic [31:0] dc_v   [3];

  assign wren_v[0] = bus0.wren_o;      assign wren_v[1] = bus1.wren_o;      assign wren_v[2] = bus2.wren_o;
  assign rden_v[0] = bus0.rden_o;      assign rden_v[1] = bus1.rden_o;      assign rden_v[2] = bus2.rden_o;
  assign addr_v[0] = bus0.addr_32b_o;  assign addr_v[1] = bus1.addr_32b_o;  assign addr_v[2] = bus2.addr_32b_o;
  assign din_v[0]  = bus0.din_32b_o;   assign din_v[1]  = bus1.din_32b_o;   assign din_v[2]  = bus2.din_32b_o;
  assign lc_v[0]   = 32'(lc0);         assign lc_v[1]   = 32'(lc1);         assign lc_v[2]   = 32'(lc2);
  assign dc_v[0]   = 32'(dc0);         assign dc_v[1]   = 32'(dc1);         assign dc_v[2]   = 32'(dc2);
  assign busy_v[0] = bz0;              assign busy_v[1] = bz1;              assign busy_v[2] = bz2;

  assign bus0.interrupt_i = irq_v[0];    assign bus1.interrupt_i = irq_v[1];    assign bus2.interrupt_i = irq_v[2];
  assign bus0.dout_32b_valid_i = valid_v[0];
  assign bus1.dout_32b_valid_i = valid_v[1];
  assign bus2.dout_32b_valid_i = valid_v[2];
  assign bus0.dout_32b_i = dout_v[0];    assign bus1.dout_32b_i = dout_v[1];    assign bus2.dout_32b_i = dout_v[2];

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc   = 0;
  logic [7:0] rx_q  [3][$];
  logic [7:0] exp_q [3][$];
  int         wr_cnt  [3];
  int         rd_cnt  [3];
  int         last_stb[3];
  bit         no_resp [3];
  bit         late_req[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, req);
    end
  endtask

  // UART model and write scoreboard for one instance, run once per negedge.
  task automatic service(input int i);
    logic [7:0] b;
    valid_v[i] = 1'b0;
    if (wren_v[i] || rden_v[i]) begin
      check($sformatf("inst%0d_strobe_exclusive", i), 32'(wren_v[i] & rden_v[i]), 32'd0);
      if (last_stb[i] >= 0)
        check($sformatf("inst%0d_strobe_gap", i), 32'((cyc - last_stb[i]) >= GAP), 32'd1);
      last_stb[i] = cyc;
    end
    if (wren_v[i]) begin
      wr_cnt[i]++;
      $display("cyc %0d inst%0d WRITE addr=%08h data=%08h", cyc, i, addr_v[i], din_v[i]);
      check($sformatf("inst%0d_wr_addr", i), addr_v[i], DEF_TX_ADDR);
      if (exp_q[i].size() == 0) begin
        check($sformatf("inst%0d_wr_unexpected", i), din_v[i], 32'hffff_ffff);
      end else begin
        b = exp_q[i].pop_front();
        check($sformatf("inst%0d_wr_data", i), din_v[i], {24'h0, b});
      end
    end
    if (rden_v[i]) begin
      rd_cnt[i]++;
      $display("cyc %0d inst%0d READ  addr=%08h", cyc, i, addr_v[i]);
      check($sformatf("inst%0d_rd_addr", i), addr_v[i], DEF_RX_ADDR);
      if (rx_q[i].size() != 0) begin
        b = rx_q[i].pop_front();
        if (!no_resp[i]) begin
          dout_v[i]  = {24'h0, b};
          valid_v[i] = 1'b1;
        end
      end
    end else if (late_req[i]) begin
      late_req[i] = 1'b0;
      dout_v[i]   = 32'h55;
      valid_v[i]  = 1'b1;
      $display("cyc %0d inst%0d stray read-data pulse", cyc, i);
    end
    irq_v[i] = (rx_q[i].size() != 0);
  endtask

  task automatic tick();
    @(negedge sys_clk);
    cyc++;
    for (int i = 0; i < 3; i++) service(i);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input int i, input string s);
    for (int k = 0; k < s.len(); k++) rx_q[i].push_back(s[k]);
  endtask

  task automatic expect_bytes(input int i, input string s);
    for (int k = 0; k < s.len(); k++) exp_q[i].push_back(s[k]);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_inst%0d_addr", tag, i), addr_v[i], 32'd0);
      check($sformatf("%s_inst%0d_din", tag, i), din_v[i], 32'd0);
      check($sformatf("%s_inst%0d_wren", tag, i), 32'(wren_v[i]), 32'd0);
      check($sformatf("%s_inst%0d_rden", tag, i), 32'(rden_v[i]), 32'd0);
      check($sformatf("%s_inst%0d_line_cnt", tag, i), lc_v[i], 32'd0);
      check($sformatf("%s_inst%0d_drop_cnt", tag, i), dc_v[i], 32'd0);
      check($sformatf("%s_inst%0d_busy", tag, i), 32'(busy_v[i]), 32'd0);
    end
  endtask

  initial begin
    int wr0;
    for (int i = 0; i < 3; i++) begin
      irq_v[i] = 1'b0; valid_v[i] = 1'b0; dout_v[i] = 32'd0;
      wr_cnt[i] = 0; rd_cnt[i] = 0; last_stb[i] = -1;
      no_resp[i] = 1'b0; late_req[i] = 1'b0;
    end

    // Reset state
    rst_n = 1'b0;
    wait_ticks(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_ticks(2);

    // 1: line mode holds "AbA" until CR, then A->B substitution and CR,LF
    load(0, "AbA");
    for (int k = 0; k < 400 && rx_q[0].size() != 0; k++) tick();
    wait_ticks(40);
    check("t1_no_write_before_cr", 32'(wr_cnt[0]), 32'd0);
    check("t1_line_cnt_before_cr", lc_v[0], 32'd0);
    check("t1_busy_buffered", 32'(busy_v[0]), 32'd1);
    expect_bytes(0, "BbB");
    exp_q[0].push_back(ASCII_CR);
    exp_q[0].push_back(ASCII_LF);
    rx_q[0].push_back(ASCII_CR);
    for (int k = 0; k < 200 && lc_v[0] != 1; k++) tick();
    check("t1_line_cnt_up", lc_v[0], 32'd1);
    for (int k = 0; k < 1000 && exp_q[0].size() != 0; k++) tick();
    check("t1_all_written", 32'(exp_q[0].size()), 32'd0);
    wait_ticks(40);
    check("t1_write_count", 32'(wr_cnt[0]), 32'd5);
    check("t1_line_cnt_down", lc_v[0], 32'd0);
    check("t1_idle", 32'(busy_v[0]), 32'd0);

    // 2: byte mode, no CRLF expansion
    expect_bytes(1, "xy");
    load(1, "xy");
    for (int k = 0; k < 500 && exp_q[1].size() != 0; k++) tick();
    check("t2_all_written", 32'(exp_q[1].size()), 32'd0);
    wait_ticks(40);
    check("t2_write_count", 32'(wr_cnt[1]), 32'd2);
    check("t2_line_cnt", lc_v[1], 32'd0);
    check("t2_idle", 32'(busy_v[1]), 32'd0);

    // 3: depth-4 buffer overflow with reserved CR slot
    load(2, "pqrst");
    rx_q[2].push_back(ASCII_CR);
    load(2, "z");
    expect_bytes(2, "pqr");
    exp_q[2].push_back(ASCII_CR);
    exp_q[2].push_back(ASCII_LF);
    for (int k = 0; k < 1000 && exp_q[2].size() != 0; k++) tick();
    check("t3_all_written", 32'(exp_q[2].size()), 32'd0);
    wait_ticks(40);
    check("t3_write_count", 32'(wr_cnt[2]), 32'd5);
    check("t3_drop_cnt", dc_v[2], 32'd3);
    check("t3_line_cnt", lc_v[2], 32'd0);
    check("t3_idle", 32'(busy_v[2]), 32'd0);

    // 4: reads win while interrupt is high; pending LF beats a new read
    load(0, "hi");
    rx_q[0].push_back(ASCII_CR);
    expect_bytes(0, "hi");
    exp_q[0].push_back(ASCII_CR);
    exp_q[0].push_back(ASCII_LF);
    for (int k = 0; k < 300 && lc_v[0] != 1; k++) tick();
    check("t4_line_pending", lc_v[0], 32'd1);
    wr0 = wr_cnt[0];
    load(0, "klmnop");
    for (int k = 0; k < 400 && rx_q[0].size() != 0; k++) tick();
    check("t4_reads_win", 32'(wr_cnt[0]), 32'(wr0));
    for (int k = 0; k < 400 && !(wren_v[0] && din_v[0] == 32'h0d); k++) tick();
    check("t4_cr_written", din_v[0], 32'h0d);
    load(0, "w");
    for (int k = 0; k < 100 && !(wren_v[0] || rden_v[0]); k++) tick();
    check("t4_lf_before_read", {30'd0, wren_v[0], rden_v[0]}, 32'd2);
    for (int k = 0; k < 200 && rx_q[0].size() != 0; k++) tick();
    wait_ticks(40);
    check("t4_all_written", 32'(exp_q[0].size()), 32'd0);
    check("t4_partial_line_held", 32'(busy_v[0]), 32'd1);
    check("t4_line_cnt", lc_v[0], 32'd0);

    // 5: read timeout, then a stray valid pulse is ignored
    no_resp[1] = 1'b1;
    load(1, "Q");
    for (int k = 0; k < 100 && !rden_v[1]; k++) tick();
    check("t5_read_issued", 32'(rden_v[1]), 32'd1);
    wr0 = wr_cnt[1];
    wait_ticks(14);
    check("t5_still_waiting", 32'(busy_v[1]), 32'd1);
    wait_ticks(1);
    check("t5_timed_out", 32'(busy_v[1]), 32'd0);
    wait_ticks(5);
    late_req[1] = 1'b1;
    wait_ticks(60);
    check("t5_nothing_sent", 32'(wr_cnt[1]), 32'(wr0));
    check("t5_buffer_empty", 32'(busy_v[1]), 32'd0);
    check("t5_line_cnt", lc_v[1], 32'd0);
    no_resp[1] = 1'b0;

    // 6: asynchronous reset mid-line (inst2) and mid-LF (inst0)
    load(2, "zz");
    expect_bytes(0, "klmnopw");
    exp_q[0].push_back(ASCII_CR);
    exp_q[0].push_back(ASCII_LF);
    rx_q[0].push_back(ASCII_CR);
    for (int k = 0; k < 600 && !(wren_v[0] && din_v[0] == 32'h0d); k++) tick();
    check("t6_cr_written", din_v[0], 32'h0d);
    check("t6_partial_line_inst2", 32'(busy_v[2]), 32'd1);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      rx_q[i].delete();
    end
    wait_ticks(3);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) last_stb[i] = -1;
    wr0 = wr_cnt[0] + wr_cnt[1] + wr_cnt[2];
    wait_ticks(100);
    check("t6_no_writes_after_reset", 32'(wr_cnt[0] + wr_cnt[1] + wr_cnt[2]), 32'(wr0));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_inst%0d_line_cnt", i), lc_v[i], 32'd0);
      check($sformatf("t6_inst%0d_idle", i), 32'(busy_v[i]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
